bcd_ascii_serializer: RTL and testbench
=======================================

// Module: bcd_ascii_serializer
// PURPOSE
//  Consumes the packed BCD word produced by hex2bcd and emits it as ASCII
//  characters, most significant digit first, on a byte-wide valid/ready stream.
//  Optional leading-zero suppression or space padding; optional CR/LF terminator.
//  Sits between hex2bcd and the UART/console transmitter.
// PARAMETERS
//  NUM_DIGITS      3   BCD digits in bcd_in (matches hex2bcd 2-nybble output = 12 bits)
//  SUPPRESS_ZEROS  1   1 = leading zeros not printed as '0'; 0 = every digit printed
//  PAD_WITH_SPACE  0   when SUPPRESS_ZEROS=1: 1 = suppressed digit sent as ' ' (0x20), 0 = dropped
//  APPEND_CRLF     1   1 = 0x0D,0x0A sent after the last digit
// PORTS
//  clock      in   1             single clock domain
//  reset      in   1             asynchronous, active-low
//  bcd_in     in   NUM_DIGITS*4  packed BCD, digit k = bcd_in[4k+3:4k]; digit NUM_DIGITS-1 is MSD
//  in_valid   in   1             bcd_in holds a word to print
//  in_ready   out  1             block accepts a word (registered)
//  out_data   out  8             ASCII character (registered)
//  out_valid  out  1             out_data valid (registered)
//  out_ready  in   1             downstream accepts out_data
//  busy       out  1             frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset (reset low, async): state=IDLE, in_ready=0, out_valid=0, out_data=8'h00, busy=0.
//   in_ready rises on the first clock edge after reset is released.
//  Input handshake: transfer when in_valid && in_ready at a rising edge. bcd_in is captured into a
//   hold register; in_ready drops on the same edge and stays low until the frame completes.
//   in_valid while busy is ignored; nothing is queued.
//  FSM: IDLE -> DIGITS -> (CR -> LF ->) IDLE.
//   IDLE: in_ready=1. On transfer: idx<=NUM_DIGITS-1, leading<=SUPPRESS_ZEROS, go to DIGITS.
//   DIGITS: d = hold[4*idx+:4]. Byte selection:
//    - leading && d==0 && idx!=0: emit 0x20 if PAD_WITH_SPACE, else emit nothing.
//      A dropped digit costs one cycle with out_valid=0, then idx decrements.
//    - otherwise: emit 0x30+d for d<=9, or '?' (0x3F) for d>=10; clear leading.
//    - The LSD (idx=0) is always printed, so a zero word prints "0".
//   Completion of the LSD byte goes to CR if APPEND_CRLF, else to IDLE.
//   CR emits 0x0D, then goes to LF. LF emits 0x0A, then goes to IDLE.
//   in_ready is reasserted on the edge that completes the final byte.
//  Output handshake:
//   - A byte is complete on an edge where out_valid && out_ready.
//   - While out_valid && !out_ready, out_data and the state are frozen (no change permitted).
//   - On completion the next byte is loaded on that same edge, so with out_ready tied high
//     there is one byte per cycle and no bubbles (except dropped digits).
//  Latency: transfer edge -> out_valid=1 on the next edge. Exception: when the MSD is dropped,
//   add one cycle per dropped digit.
//  Throughput: NUM_DIGITS + 2*APPEND_CRLF bytes per frame, plus 1 IDLE cycle between frames.
//  Reset mid-frame: out_valid deasserts immediately (async); the partial frame is discarded and
//   nothing is resumed. The next accepted word prints a complete frame.
//  out_ready is don't-care when out_valid=0.
// STRUCTURE
//  Shared package (hdl_ascii_pkg):
//   - ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, ASCII_QMARK=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
//   - State encoding localparams: IDLE, DIGITS, CR, LF.
//  Sub-module: bcd_digit_to_ascii (combinational): 4-bit digit -> 8-bit char,
//   applying the '?' rule for d>=10.
//  idx width $clog2(NUM_DIGITS), minimum 1.
// TESTING
//  1) bcd_in=12'h255, out_ready=1 -> 0x32,0x35,0x35,0x0D,0x0A on 5 consecutive cycles;
//     in_ready high the cycle after LF.
//  2) bcd_in=12'h007, SUPPRESS_ZEROS=1, PAD=0 -> 0x37,0x0D,0x0A, with 2 out_valid=0 cycles
//     first. With PAD=1 -> 0x20,0x20,0x37,0x0D,0x0A.
//  3) bcd_in=12'h000 -> 0x30,0x0D,0x0A. With SUPPRESS_ZEROS=0 -> 0x30,0x30,0x30,0x0D,0x0A.
//  4) bcd_in=12'h128, random out_ready (~30% high) -> same 5 bytes in order; out_data stable
//     whenever out_valid && !out_ready; in_valid pulses while busy are ignored.
//  5) bcd_in=12'h2A5 -> 0x32,0x3F,0x35,0x0D,0x0A.
//  6) Assert reset during the 2nd byte of 12'h255 -> out_valid=0 with no clock edge.
//     After release, 12'h099 -> 0x39,0x39,0x0D,0x0A (suppression on).

Source files
------------

// File: rtl/hdl_ascii_pkg.sv
// -----------------------------------------------------------------------------
// hdl_ascii_pkg
// Shared ASCII constants and the serializer state encoding used by the BCD to
// ASCII output path.
// No ports (package).
// -----------------------------------------------------------------------------
package hdl_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    CR     = 2'd2,
    LF     = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_ascii_serializer_if.sv
// -----------------------------------------------------------------------------
// bcd_ascii_serializer_if
// Bundles the BCD input handshake and the byte-wide output stream of the
// serializer.
//   bcd_in    packed BCD word, digit k at [4k+3:4k]
//   in_valid  / in_ready   input word handshake
//   out_data  / out_valid / out_ready   ASCII byte stream
//   busy      frame in progress
// Modports: slave = serializer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface bcd_ascii_serializer_if #(
  parameter int NUM_DIGITS = 3
) ();

  logic [NUM_DIGITS*4-1:0] bcd_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport slave (
    input  bcd_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );

  modport master (
    output bcd_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/bcd_digit_to_ascii.sv
// -----------------------------------------------------------------------------
// bcd_digit_to_ascii
// Combinational conversion of one BCD digit to its ASCII character. Values
// 10..15 are not legal BCD and are rendered as '?'.
//   digit  in   4  BCD digit
//   ascii  out  8  ASCII character
// -----------------------------------------------------------------------------
module bcd_digit_to_ascii
  import hdl_ascii_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_QMARK;
    if (digit <= 4'd9) begin
      ascii = ASCII_ZERO + {4'h0, digit};
    end
  end

endmodule

// File: rtl/bcd_ascii_serializer.sv
// -----------------------------------------------------------------------------
// bcd_ascii_serializer
// Takes a packed BCD word and streams it as ASCII, most significant digit
// first, with optional leading-zero suppression (drop or space pad) and an
// optional CR/LF terminator.
//   clock  in  1   clock
//   reset  in  1   asynchronous, active-low
//   bus    slave modport of bcd_ascii_serializer_if (bcd_in, in_valid,
//          in_ready, out_data, out_valid, out_ready, busy)
// -----------------------------------------------------------------------------
module bcd_ascii_serializer
  import hdl_ascii_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int SUPPRESS_ZEROS = 1,
  parameter int PAD_WITH_SPACE = 0,
  parameter int APPEND_CRLF    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  bcd_ascii_serializer_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOTS = 1 << IDX_W;

  state_t                  state_reg;
  logic [NUM_DIGITS*4-1:0] hold_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    leading_reg;
  logic [7:0]              out_data_reg;
  logic                    out_valid_reg;
  logic                    in_ready_reg;

  // Digit slots padded to a power of two so any idx value selects safely.
  logic [3:0] digit_slot [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_DIGITS) begin : g_real
        assign digit_slot[gi] = hold_reg[4*gi +: 4];
      end else begin : g_pad
        assign digit_slot[gi] = 4'h0;
      end
    end
  endgenerate

  // idx_reg names the digit currently on out_data when out_valid is high,
  // and the next digit to evaluate otherwise. ld_idx is the digit to load
  // on this edge if the output slot frees up.
  logic             advance;
  logic [IDX_W-1:0] ld_idx;
  logic [3:0]       ld_digit;
  logic [7:0]       ld_char;
  logic             ld_skip;

  always_comb begin
    advance  = !out_valid_reg || bus.out_ready;
    ld_idx   = out_valid_reg ? (idx_reg - IDX_W'(1)) : idx_reg;
    ld_digit = digit_slot[ld_idx];
    // The LSD is never suppressed so an all-zero word still prints "0".
    ld_skip  = leading_reg && (ld_digit == 4'h0) && (ld_idx != '0);
  end

  bcd_digit_to_ascii u_conv (
    .digit (ld_digit),
    .ascii (ld_char)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      idx_reg       <= '0;
      leading_reg   <= 1'b0;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            hold_reg     <= bus.bcd_in;
            idx_reg      <= IDX_W'(NUM_DIGITS - 1);
            leading_reg  <= (SUPPRESS_ZEROS != 0);
            in_ready_reg <= 1'b0;
            state_reg    <= DIGITS;
          end
        end
        DIGITS: begin
          if (advance) begin
            if (out_valid_reg && (idx_reg == '0)) begin
              // LSD byte completes here.
              if (APPEND_CRLF != 0) begin
                state_reg    <= CR;
                out_data_reg <= ASCII_CR;
              end else begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                in_ready_reg  <= 1'b1;
              end
            end else if (ld_skip) begin
              if (PAD_WITH_SPACE != 0) begin
                out_data_reg  <= ASCII_SPACE;
                out_valid_reg <= 1'b1;
                idx_reg       <= ld_idx;
              end else begin
                // Dropped digit: one idle output cycle, move to next digit.
                out_valid_reg <= 1'b0;
                idx_reg       <= ld_idx - IDX_W'(1);
              end
            end else begin
              out_data_reg  <= ld_char;
              out_valid_reg <= 1'b1;
              leading_reg   <= 1'b0;
              idx_reg       <= ld_idx;
            end
          end
        end
        CR: begin
          if (bus.out_ready) begin
            state_reg    <= LF;
            out_data_reg <= ASCII_LF;
          end
        end
        LF: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// -----------------------------------------------------------------------------
// tb_bcd_ascii_serializer
// Three serializer instances: 0 = suppress/drop (default), 1 = suppress/pad
// with spaces, 2 = no suppression. Directed words are issued per instance;
// the expected bytes go into a per-instance queue and a negedge monitor pops
// and compares every byte handed over on the output stream.
// -----------------------------------------------------------------------------
module tb_bcd_ascii_serializer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [11:0] tb_bcd = '0;
  logic [2:0]  vld    = '0;
  logic [2:0]  rdy    = 3'b111;
  logic [2:0]  ov, ir, bz;
  logic [7:0]  od [3];

  logic [7:0]  exp_q [3][$];
  int          n_vec = 0;
  int          n_bad = 0;

  logic [2:0]  held_v = '0;
  logic [7:0]  held_d [3];
  logic [7:0]  mon_exp;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      bcd_ascii_serializer_if #(.NUM_DIGITS(3)) bus ();
      assign bus.bcd_in    = tb_bcd;
      assign bus.in_valid  = vld[gi];
      assign bus.out_ready = rdy[gi];
      assign ov[gi]        = bus.out_valid;
      assign ir[gi]        = bus.in_ready;
      assign bz[gi]        = bus.busy;
      assign od[gi]        = bus.out_data;

      bcd_ascii_serializer #(
        .NUM_DIGITS     (3),
        .SUPPRESS_ZEROS ((gi == 2) ? 0 : 1),
        .PAD_WITH_SPACE ((gi == 1) ? 1 : 0),
        .APPEND_CRLF    (1)
      ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic check1(input string name, input logic got, input logic req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0b required %0b", name, got, req);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h", name, got, req);
    end
  endtask

  // Scoreboard monitor: compares each accepted byte, and checks that a
  // stalled byte stays on the bus unchanged.
  always @(negedge clock) begin
    if (!reset) begin
      held_v = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (held_v[k]) begin
          check1($sformatf("stall_valid_dut%0d", k), ov[k], 1'b1);
          check8($sformatf("stall_data_dut%0d", k), od[k], held_d[k]);
        end
        if (ov[k] && rdy[k]) begin
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_byte_dut%0d: got %02h required no byte", k, od[k]);
          end else begin
            mon_exp = exp_q[k].pop_front();
            $display("[%0t] dut%0d byte %02h (expect %02h)", $time, k, od[k], mon_exp);
            check8($sformatf("byte_dut%0d", k), od[k], mon_exp);
          end
        end
        held_v[k] = ov[k] && !rdy[k];
        held_d[k] = od[k];
      end
    end
  end

  task automatic push(input int k, input logic [39:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      exp_q[k].push_back(b[8*i +: 8]);
    end
  endtask

  task automatic send(input int k, input logic [11:0] w);
    int t = 0;
    while (!ir[k] && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!ir[k]) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout_dut%0d: in_ready 0 required 1", k);
    end else begin
      tb_bcd = w;
      vld[k] = 1'b1;
      @(posedge clock); #1;
      vld[k] = 1'b0;
      $display("[%0t] dut%0d word %03h accepted", $time, k, w);
    end
  endtask

  task automatic finish_frame(input int k);
    int t = 0;
    while (!(ir[k] && exp_q[k].size() == 0) && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    check1($sformatf("frame_done_dut%0d", k), ir[k] && (exp_q[k].size() == 0), 1'b1);
    check1($sformatf("idle_busy_dut%0d", k), bz[k], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #12;
    check8("rst_out_data", od[0], 8'h00);
    check1("rst_out_valid", ov[0], 1'b0);
    check1("rst_in_ready", ir[0], 1'b0);
    check1("rst_busy", bz[0], 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check1("in_ready_after_reset", ir[0], 1'b1);

    // 1) 255 back-to-back bytes
    push(0, 40'h3235350D0A, 5);
    send(0, 12'h255);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock); #1;
      check1($sformatf("t1_valid_cycle%0d", c), ov[0], 1'b1);
    end
    @(posedge clock); #1;
    check1("t1_in_ready_after_lf", ir[0], 1'b1);
    finish_frame(0);

    // 2) 007 dropped leading zeros, then space padded
    push(0, 40'h370D0A, 3);
    send(0, 12'h007);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clock); #1;
      check1($sformatf("t2_drop_gap%0d", c), ov[0], 1'b0);
    end
    @(posedge clock); #1;
    check1("t2_first_byte_valid", ov[0], 1'b1);
    finish_frame(0);
    push(1, 40'h2020370D0A, 5);
    send(1, 12'h007);
    finish_frame(1);

    // 3) all zeros, with and without suppression; 007 unsuppressed
    push(0, 40'h300D0A, 3);
    send(0, 12'h000);
    finish_frame(0);
    push(2, 40'h3030300D0A, 5);
    send(2, 12'h000);
    finish_frame(2);
    push(2, 40'h3030370D0A, 5);
    send(2, 12'h007);
    finish_frame(2);

    // 5) illegal BCD digit
    push(0, 40'h323F350D0A, 5);
    send(0, 12'h2A5);
    finish_frame(0);

    // 4) 128 under random backpressure, with in_valid pulses while busy
    push(0, 40'h3132380D0A, 5);
    send(0, 12'h128);
    begin
      int t = 0;
      while (!(ir[0] && exp_q[0].size() == 0) && t < 400) begin
        @(posedge clock); #1;
        t++;
        rdy[0] = ($urandom_range(0, 9) < 3);
        if (!ir[0] && (t % 3 == 0)) begin
          tb_bcd = 12'h999;
          vld[0] = 1'b1;
        end else begin
          vld[0] = 1'b0;
        end
      end
    end
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    finish_frame(0);

    // 6) reset during the second byte of 255, then 099
    push(0, 40'h3235350D0A, 5);
    send(0, 12'h255);
    @(posedge clock); #1;
    check1("t6_first_byte_valid", ov[0], 1'b1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check1("t6_async_out_valid", ov[0], 1'b0);
    check8("t6_async_out_data", od[0], 8'h00);
    check1("t6_async_busy", bz[0], 1'b0);
    check1("t6_async_in_ready", ir[0], 1'b0);
    exp_q[0].delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    push(0, 40'h39390D0A, 4);
    send(0, 12'h099);
    finish_frame(0);

    for (int k = 0; k < 3; k++) begin
      check1($sformatf("queue_empty_dut%0d", k), exp_q[k].size() == 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
